pipelined_carry_alu: RTL and testbench
======================================

// Module: pipelined_carry_alu
// PURPOSE
//  Width-parametrised ALU slice; successor to the fixed 4-bit combinational carry/propagate
//  unit. Carry chain is split into STAGES registered chunks with a valid/ready pipeline.
//  Adds SUB/XOR/AND modes, carry-in, and registered group flags (propagate, all-ones, zero).
//  Sits between the operand-select mux and the result/flag writeback in the datapath.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of carry-chain chunks (1..WIDTH)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in; ignored for SUB (forced 1), XOR, AND
//  in_op      in   2      00 ADD, 01 SUB (A + ~B + 1), 10 XOR, 11 AND
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  out_res    out  WIDTH  result
//  out_cout   out  1      carry-out of MSB (ADD/SUB), 0 for XOR/AND
//  out_prop   out  1      group propagate: &(A ^ B') where B' is B or ~B for SUB
//  out_ones   out  1      &out_res
//  out_zero   out  1      ~|out_res
// BEHAVIOUR
//  - Reset: every stage valid bit, out_valid, out_res, out_cout, out_prop, out_ones,
//    out_zero cleared to 0 immediately (async); in_ready = 1 out of reset.
//  - CHUNK = WIDTH/STAGES. Stage k (0-based) computes bits [k*CHUNK +: CHUNK] from the
//    carry registered by stage k-1 (stage 0 uses effective cin) and registers its slice,
//    its carry, a running propagate AND, and the remaining operand slices plus op.
//  - Latency: accepted beat appears on out_* exactly STAGES cycles later with no stall.
//  - Throughput: one beat per cycle when out_ready=1.
//  - Handshake: transfer in when in_valid & in_ready; out when out_valid & out_ready.
//    out_* hold stable while out_valid & ~out_ready. in_valid may drop without ready.
//  - Stall: stage k advances if stage k+1 is empty or advancing (bubble collapse);
//    in_ready = ~valid[0] | advance[0] (combinational from out_ready chain, no skid).
//  - Empty pipe with out_ready=0: STAGES beats accepted, then in_ready=0.
//  - Simultaneous in and out transfer on a full pipe: both occur, occupancy unchanged.
//  - Flags are computed in the last stage from the registered full result; out_ones and
//    out_zero are mutually exclusive except never both (WIDTH>=1).
//  - Arithmetic is modulo 2^WIDTH; overflow visible only through out_cout.
//  - Reset mid-operation: all in-flight beats discarded, no partial result emitted.
//  - STAGES=1: purely a single registered stage, latency 1.
//  - WIDTH % STAGES != 0: elaboration-time $error.
// STRUCTURE
//  - Shared package alu_pkg: typedef enum logic [1:0] alu_op_e {OP_ADD, OP_SUB, OP_XOR,
//    OP_AND}; localparam helpers for chunk width.
//  - One sub-module: carry_chunk (CHUNK-bit combinational add/logic with cin, cout,
//    chunk propagate), instanced per stage by generate loop; pipeline regs stay in top.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 at once,
//    in_ready=1 after release, no stale beat ever emitted.
//  2 ADD WIDTH=16: A=FFFF, B=0001, cin=0 -> res=0000, cout=1, zero=1, ones=0, prop=0,
//    after exactly 4 cycles.
//  3 SUB: A=0005, B=0007 -> res=FFFE, cout=0, ones=0; A=B=1234 -> res=0, cout=1, zero=1.
//  4 Logic: XOR A=AAAA, B=5555 -> res=FFFF, ones=1, prop=1, cout=0; AND same -> res=0000.
//  5 Backpressure: out_ready=0, drive 6 beats back-to-back -> 4 accepted then in_ready=0;
//    release out_ready -> 4 results in order, one per cycle, values unchanged while held.
//  6 Carry across every chunk boundary: A=0FFF, B=0001, cin=1 -> res=1001 with STAGES=4,
//    re-run STAGES=1 and 16 -> identical result, latencies 1 and 16.

Source files
------------

// File: rtl/pipelined_carry_alu_pkg.sv
// Shared definitions for the pipelined carry ALU slice.
//   alu_op_e  : operation encoding carried on in_op and down the pipeline
//   chunk_w() : bits handled by each pipeline stage
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_XOR = 2'b10,
        OP_AND = 2'b11
    } alu_op_e;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_STAGES = 4;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_carry_alu_if.sv
// Operand/result handshake bundle for pipelined_carry_alu.
//   in_valid/in_ready/in_a/in_b/in_cin/in_op : operand beat (master -> slave)
//   out_valid/out_ready/out_res/out_cout/out_prop/out_ones/out_zero : result beat
//   modport slave  : the ALU side
//   modport master : the operand source / result sink side
interface pipelined_carry_alu_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    alu_op_e          in_op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_cout;
    logic             out_prop;
    logic             out_ones;
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
        output in_ready, out_valid, out_res, out_cout, out_prop, out_ones, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_cout, out_prop, out_ones, out_zero
    );

endinterface

// File: rtl/pipelined_carry_alu_carry_chunk.sv
// One carry-chain chunk: CW-bit combinational add or bitwise logic.
//   i_a, i_b : operand slices (i_b already inverted by the caller for SUB)
//   i_cin    : carry into this chunk
//   i_op     : operation
//   o_sum    : chunk result
//   o_cout   : carry out of the chunk MSB (0 for XOR/AND)
//   o_prop   : chunk propagate, &(i_a ^ i_b)
module carry_chunk
    import alu_pkg::*;
#(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_cin,
    input  alu_op_e       i_op,
    output logic [CW-1:0] o_sum,
    output logic          o_cout,
    output logic          o_prop
);

    logic [CW:0] w_add;

    assign w_add  = {1'b0, i_a} + {1'b0, i_b} + {{CW{1'b0}}, i_cin};
    assign o_prop = &(i_a ^ i_b);

    always_comb begin
        o_sum  = w_add[CW-1:0];
        o_cout = w_add[CW];
        case (i_op)
            OP_XOR: begin
                o_sum  = i_a ^ i_b;
                o_cout = 1'b0;
            end
            OP_AND: begin
                o_sum  = i_a & i_b;
                o_cout = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipelined_carry_alu.sv
// Width-parametrised ALU slice with the carry chain split over STAGES registered
// chunks and a valid/ready pipeline. Latency STAGES, one beat per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipelined_carry_alu_if.slave (operand beat in, result beat out)
module pipelined_carry_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_carry_alu_if.slave  bus
);

    localparam int unsigned CW   = chunk_w(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_err
        $error("pipelined_carry_alu: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Per-stage pipeline registers. Stage k holds a partial result whose chunks
    // 0..k are final, plus the full operands so later stages can finish the sum.
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_p;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_res [STAGES];
    alu_op_e           r_op  [STAGES];
    logic              r_ones;
    logic              r_zero;

    // Inputs feeding each stage (stage 0 from the bus, stage k from stage k-1).
    logic [STAGES-1:0] w_src_v;
    logic [STAGES-1:0] w_src_c;
    logic [STAGES-1:0] w_src_p;
    logic [WIDTH-1:0]  w_src_a   [STAGES];
    logic [WIDTH-1:0]  w_src_b   [STAGES];
    logic [WIDTH-1:0]  w_src_res [STAGES];
    alu_op_e           w_src_op  [STAGES];

    logic [CW-1:0]     w_sum     [STAGES];
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_cprop;
    logic [WIDTH-1:0]  w_nxt_res [STAGES];
    logic [STAGES-1:0] w_adv;

    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;

    // SUB is A + ~B + 1; the carry-in is only honoured for ADD.
    always_comb begin
        w_b_eff   = bus.in_b;
        w_cin_eff = 1'b0;
        case (bus.in_op)
            OP_ADD: w_cin_eff = bus.in_cin;
            OP_SUB: begin
                w_b_eff   = ~bus.in_b;
                w_cin_eff = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_src_v      = '0;
        w_src_c      = '0;
        w_src_p      = '0;
        w_src_v[0]   = bus.in_valid;
        w_src_c[0]   = w_cin_eff;
        w_src_p[0]   = 1'b1;
        w_src_a[0]   = bus.in_a;
        w_src_b[0]   = w_b_eff;
        w_src_res[0] = '0;
        w_src_op[0]  = bus.in_op;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_src_v[k]   = r_vld[k-1];
            w_src_c[k]   = r_c[k-1];
            w_src_p[k]   = r_p[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_res[k] = r_res[k-1];
            w_src_op[k]  = r_op[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_chunk
        carry_chunk #(.CW(CW)) u_chunk (
            .i_a    (w_src_a[g][g*CW +: CW]),
            .i_b    (w_src_b[g][g*CW +: CW]),
            .i_cin  (w_src_c[g]),
            .i_op   (w_src_op[g]),
            .o_sum  (w_sum[g]),
            .o_cout (w_cout[g]),
            .o_prop (w_cprop[g])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_nxt_res[k]             = w_src_res[k];
            w_nxt_res[k][k*CW +: CW] = w_sum[k];
        end
    end

    // Stage k may load when it is empty or its content moves on this cycle;
    // evaluated from the output end back so bubbles collapse in one cycle.
    always_comb begin
        w_adv       = '0;
        w_adv[LAST] = ~r_vld[LAST] | bus.out_ready;
        for (int unsigned j = 1; j < STAGES; j++) begin
            w_adv[LAST-j] = ~r_vld[LAST-j] | w_adv[LAST-j+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_c    <= '0;
            r_p    <= '0;
            r_ones <= 1'b0;
            r_zero <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
                r_op[k]  <= OP_ADD;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_c[k]   <= w_cout[k];
                        r_p[k]   <= w_src_p[k] & w_cprop[k];
                        r_a[k]   <= w_src_a[k];
                        r_b[k]   <= w_src_b[k];
                        r_res[k] <= w_nxt_res[k];
                        r_op[k]  <= w_src_op[k];
                    end
                end
            end
            if (w_adv[LAST] && w_src_v[LAST]) begin
                r_ones <= &w_nxt_res[LAST];
                r_zero <= ~|w_nxt_res[LAST];
            end
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_vld[LAST];
    assign bus.out_res   = r_res[LAST];
    assign bus.out_cout  = r_c[LAST];
    assign bus.out_prop  = r_p[LAST];
    assign bus.out_ones  = r_ones;
    assign bus.out_zero  = r_zero;

endmodule

// File: tb/tb_pipelined_carry_alu.sv
// Directed bench for pipelined_carry_alu: STAGES=4 main instance plus STAGES=1
// and STAGES=16 instances for the chunk-boundary carry/latency comparison.
module tb_pipelined_carry_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pipelined_carry_alu_if #(.WIDTH(16)) ifc4  ();
    pipelined_carry_alu_if #(.WIDTH(16)) ifc1  ();
    pipelined_carry_alu_if #(.WIDTH(16)) ifc16 ();

    pipelined_carry_alu #(.WIDTH(16), .STAGES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc4));
    pipelined_carry_alu #(.WIDTH(16), .STAGES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    pipelined_carry_alu #(.WIDTH(16), .STAGES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(ifc16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive4(input logic v, input alu_op_e op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
        ifc4.in_valid = v;
        ifc4.in_op    = op;
        ifc4.in_a     = a;
        ifc4.in_b     = b;
        ifc4.in_cin   = cin;
    endtask

    // Present one beat on the STAGES=4 instance (out_ready=1) and count edges from
    // the accepting edge until out_valid shows; leaves the result on the outputs.
    task automatic run_beat(input string tag, input alu_op_e op, input logic [15:0] a,
                            input logic [15:0] b, input logic cin, output int lat);
        drive4(1'b1, op, a, b, cin);
        check_eq({tag, "_in_ready"}, 32'(ifc4.in_ready), 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            if (lat == 0) ifc4.in_valid = 1'b0;
            lat++;
        end while (!ifc4.out_valid && lat < 40);
    endtask

    task automatic check_res(input string tag, input logic [15:0] res, input logic cout,
                             input logic zero, input logic ones, input logic prop);
        check_eq({tag, "_valid"}, 32'(ifc4.out_valid), 32'd1);
        check_eq({tag, "_res"},   32'(ifc4.out_res),   32'(res));
        check_eq({tag, "_cout"},  32'(ifc4.out_cout),  32'(cout));
        check_eq({tag, "_zero"},  32'(ifc4.out_zero),  32'(zero));
        check_eq({tag, "_ones"},  32'(ifc4.out_ones),  32'(ones));
        check_eq({tag, "_prop"},  32'(ifc4.out_prop),  32'(prop));
    endtask

    logic [15:0] bp_exp [4] = '{16'h0111, 16'h0211, 16'h0311, 16'h0411};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int stale;
        int lat4, lat1, lat16;
        logic [15:0] res4, res1, res16;
        logic [2:0] seen;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        drive4(1'b0, OP_ADD, 16'h0, 16'h0, 1'b0);
        ifc4.out_ready  = 1'b1;
        ifc1.in_valid   = 1'b0; ifc1.in_op  = OP_ADD; ifc1.in_a  = '0; ifc1.in_b  = '0; ifc1.in_cin  = 1'b0;
        ifc16.in_valid  = 1'b0; ifc16.in_op = OP_ADD; ifc16.in_a = '0; ifc16.in_b = '0; ifc16.in_cin = 1'b0;
        ifc1.out_ready  = 1'b1;
        ifc16.out_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(ifc4.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(ifc4.in_ready),  32'd1);
        check_eq("rst_out_res",   32'(ifc4.out_res),   32'd0);
        check_eq("rst_flags",     32'({ifc4.out_cout, ifc4.out_prop, ifc4.out_ones, ifc4.out_zero}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with wrap, latency 4
        run_beat("add", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, lat);
        check_eq("add_lat", 32'(lat), 32'd4);
        check_res("add", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // SUB: 5-7 borrows, equal operands give zero with carry
        run_beat("sub1", OP_SUB, 16'h0005, 16'h0007, 1'b0, lat);
        check_res("sub1", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_beat("sub2", OP_SUB, 16'h1234, 16'h1234, 1'b0, lat);
        check_res("sub2", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Logic ops ignore cin
        run_beat("xor", OP_XOR, 16'hAAAA, 16'h5555, 1'b1, lat);
        check_res("xor", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        run_beat("and", OP_AND, 16'hAAAA, 16'h5555, 1'b1, lat);
        check_res("and", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;

        // Backpressure: fill 4 of 6 offered beats, hold, then drain in order
        ifc4.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive4(1'b1, OP_ADD, 16'(16'h0100 * (acc + 1)), 16'h0011, 1'b0);
            check_eq($sformatf("bp_in_ready_%0d", c), 32'(ifc4.in_ready), (c < 4) ? 32'd1 : 32'd0);
            if (ifc4.in_ready) acc++;
            @(posedge clk); #1;
        end
        ifc4.in_valid = 1'b0;
        check_eq("bp_accepted", 32'(acc), 32'd4);
        for (int h = 0; h < 2; h++) begin
            check_eq("bp_hold_valid", 32'(ifc4.out_valid), 32'd1);
            check_eq("bp_hold_res",   32'(ifc4.out_res),   32'(bp_exp[0]));
            @(posedge clk); #1;
        end
        ifc4.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_eq($sformatf("bp_drain_valid_%0d", j), 32'(ifc4.out_valid), 32'd1);
            check_eq($sformatf("bp_drain_res_%0d", j),   32'(ifc4.out_res),   32'(bp_exp[j]));
            @(posedge clk); #1;
        end
        check_eq("bp_empty", 32'(ifc4.out_valid), 32'd0);

        // Reset mid-stream with beats in flight
        ifc4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, OP_ADD, 16'(i + 1), 16'h0001, 1'b0);
            @(posedge clk); #1;
        end
        ifc4.in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mrst_pre_valid", 32'(ifc4.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_out_valid", 32'(ifc4.out_valid), 32'd0);
        check_eq("mrst_out_res",   32'(ifc4.out_res),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc4.out_ready = 1'b1;
        check_eq("mrst_in_ready", 32'(ifc4.in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ifc4.out_valid) stale++;
        end
        check_eq("mrst_stale", 32'(stale), 32'd0);

        // Carry through every chunk boundary on all three depths
        drive4(1'b1, OP_ADD, 16'h0FFF, 16'h0001, 1'b1);
        ifc1.in_valid  = 1'b1; ifc1.in_op  = OP_ADD; ifc1.in_a  = 16'h0FFF; ifc1.in_b  = 16'h0001; ifc1.in_cin  = 1'b1;
        ifc16.in_valid = 1'b1; ifc16.in_op = OP_ADD; ifc16.in_a = 16'h0FFF; ifc16.in_b = 16'h0001; ifc16.in_cin = 1'b1;
        check_eq("cb_rdy1",  32'(ifc1.in_ready),  32'd1);
        check_eq("cb_rdy16", 32'(ifc16.in_ready), 32'd1);
        seen = '0;
        lat4 = 0; lat1 = 0; lat16 = 0;
        res4 = '0; res1 = '0; res16 = '0;
        for (int n = 1; n <= 40 && seen != 3'b111; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                ifc4.in_valid  = 1'b0;
                ifc1.in_valid  = 1'b0;
                ifc16.in_valid = 1'b0;
            end
            if (!seen[0] && ifc4.out_valid)  begin seen[0] = 1'b1; lat4  = n; res4  = ifc4.out_res;  end
            if (!seen[1] && ifc1.out_valid)  begin seen[1] = 1'b1; lat1  = n; res1  = ifc1.out_res;  end
            if (!seen[2] && ifc16.out_valid) begin seen[2] = 1'b1; lat16 = n; res16 = ifc16.out_res; end
        end
        check_eq("cb_res_s4",  32'(res4),  32'h1001);
        check_eq("cb_res_s1",  32'(res1),  32'h1001);
        check_eq("cb_res_s16", 32'(res16), 32'h1001);
        check_eq("cb_lat_s4",  32'(lat4),  32'd4);
        check_eq("cb_lat_s1",  32'(lat1),  32'd1);
        check_eq("cb_lat_s16", 32'(lat16), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
